// File: rtl/seg7_scan_ctrl.sv
// Scan controller for two 74HC595 chains (segments + digit commons) on a multiplexed 7-segment display.
// Optional macro SEG7_BRIGHTNESS_EN: PWM the OE line during HOLD according to the brightness input.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 4,
  parameter int DWELL_STEP     = 2,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    frame_we,
  input  logic [8*NUM_DIGITS-1:0] frame_data,
  input  logic [3:0]              brightness,
  output logic [2:0]              scan_digit,
  output logic                    frame_sync,
  output logic                    seg_ser,
  output logic                    seg_srclk,
  output logic                    seg_rclk,
  output logic                    seg_oe,
  output logic                    com_ser,
  output logic                    com_srclk,
  output logic                    com_rclk,
  output logic                    com_oe
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DWL_W = (DWELL_STEP > 1) ? $clog2(DWELL_STEP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DWELL_STEP - 1);
  localparam logic [2:0]       DIG_LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_HOLD} state_t;

  state_t                  state;
  logic [8*NUM_DIGITS-1:0] shadow, active;
  logic [2:0]              digit, bit_cnt;
  logic [DIV_W-1:0]        div_cnt;
  logic [DWL_W-1:0]        sub_cnt;
  logic [3:0]              step_cnt;
  logic [7:0]              seg_sr, com_sr;
  logic                    seg_ser_q, com_ser_q, srclk_q, rclk_q, oe_q, sync_q;

  // Digit 0 reads the shadow directly so the new frame and its first glyph are taken together.
  logic [8*NUM_DIGITS-1:0] frame_src;
  logic [7:0]              seg_word, com_word, onehot;
  logic [2:0]              next_digit;

  assign frame_src  = (digit == 3'd0) ? shadow : active;
  assign onehot     = 8'd1 << digit;
  assign com_word   = COM_ACTIVE_LOW ? ~onehot : onehot;
  assign next_digit = (digit == DIG_LAST) ? 3'd0 : digit + 3'd1;

  always_comb begin
    seg_word = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (digit == 3'(i)) seg_word = frame_src[8*i +: 8];
  end

`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0] next_step;
  assign next_step = (sub_cnt == DWL_LAST) ? step_cnt + 4'd1 : step_cnt;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow <= '0;
    else if (frame_we) shadow <= frame_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      active    <= '0;
      digit     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      sub_cnt   <= '0;
      step_cnt  <= '0;
      seg_sr    <= '0;
      com_sr    <= '0;
      seg_ser_q <= 1'b0;
      com_ser_q <= 1'b0;
      srclk_q   <= 1'b0;
      rclk_q    <= 1'b0;
      oe_q      <= 1'b1;
      sync_q    <= 1'b0;
    end else begin
      sync_q <= 1'b0;
      case (state)
        S_IDLE: begin
          srclk_q   <= 1'b0;
          rclk_q    <= 1'b0;
          oe_q      <= 1'b1;
          seg_ser_q <= 1'b0;
          com_ser_q <= 1'b0;
          digit     <= '0;
          if (enable) begin
            state  <= S_LOAD;
            sync_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (digit == 3'd0) active <= shadow;
          seg_sr    <= seg_word;
          com_sr    <= com_word;
          seg_ser_q <= seg_word[7];
          com_ser_q <= com_word[7];
          div_cnt   <= '0;
          bit_cnt   <= '0;
          srclk_q   <= 1'b0;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!srclk_q) begin
              srclk_q <= 1'b1;
            end else begin
              // End of high phase: SER moves to the next bit as the low phase starts.
              srclk_q <= 1'b0;
              if (bit_cnt == 3'd7) begin
                rclk_q <= 1'b1;
                state  <= S_LATCH;
              end else begin
                bit_cnt   <= bit_cnt + 3'd1;
                seg_sr    <= {seg_sr[6:0], 1'b0};
                com_sr    <= {com_sr[6:0], 1'b0};
                seg_ser_q <= seg_sr[6];
                com_ser_q <= com_sr[6];
              end
            end
          end
        end
        S_LATCH: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt  <= '0;
            rclk_q   <= 1'b0;
            oe_q     <= 1'b0;
            sub_cnt  <= '0;
            step_cnt <= '0;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (sub_cnt == DWL_LAST && step_cnt == 4'd15) begin
            sub_cnt  <= '0;
            step_cnt <= '0;
            if (enable) begin
              state  <= S_LOAD;
              digit  <= next_digit;
              sync_q <= (next_digit == 3'd0);
`ifdef SEG7_BRIGHTNESS_EN
              oe_q   <= 1'b1;
`endif
            end else begin
              state <= S_IDLE;
              digit <= '0;
              oe_q  <= 1'b1;
            end
          end else begin
            if (sub_cnt == DWL_LAST) begin
              sub_cnt  <= '0;
              step_cnt <= step_cnt + 4'd1;
            end else begin
              sub_cnt <= sub_cnt + 1'b1;
            end
`ifdef SEG7_BRIGHTNESS_EN
            oe_q <= (next_step > brightness);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign scan_digit = digit;
  assign frame_sync = sync_q;
  assign seg_ser    = seg_ser_q;
  assign com_ser    = com_ser_q;
  assign seg_srclk  = srclk_q;
  assign com_srclk  = srclk_q;
  assign seg_rclk   = rclk_q;
  assign com_rclk   = rclk_q;
  assign seg_oe     = oe_q;
  assign com_oe     = oe_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: decodes the serial 595 streams at each RCLK and checks timing.
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, frame_we = 1'b0;
  logic [31:0] frame_data = '0;
  logic [3:0]  brightness = 4'd15;
  logic [2:0]  scan_digit;
  logic        frame_sync, seg_ser, seg_srclk, seg_rclk, seg_oe;
  logic        com_ser, com_srclk, com_rclk, com_oe;

`ifdef SEG7_BRIGHTNESS_EN
  localparam logic OE_SHIFT = 1'b1;
`else
  localparam logic OE_SHIFT = 1'b0;
`endif

  always #5 clk = ~clk;

  seg7_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_we(frame_we),
    .frame_data(frame_data), .brightness(brightness), .scan_digit(scan_digit),
    .frame_sync(frame_sync), .seg_ser(seg_ser), .seg_srclk(seg_srclk),
    .seg_rclk(seg_rclk), .seg_oe(seg_oe), .com_ser(com_ser),
    .com_srclk(com_srclk), .com_rclk(com_rclk), .com_oe(com_oe)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  int rclk_rise = 0, rclk_fall = 0, oe_fall = 0, oe_rise = 0, oe_run = 0;
  int n_sync = 0, last_sync = 0, n_oe_rise = 0, pair_err = 0;
  logic [7:0]  seg_sh = '0, com_sh = '0;
  logic        p_srclk = 1'b0, p_rclk = 1'b0, p_oe = 1'b1;
  logic [31:0] lat_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Shadow 595 model: shift on SRCLK rise, record the latched words on RCLK fall.
  initial forever begin
    @(negedge clk);
    if (seg_oe !== com_oe || seg_srclk !== com_srclk || seg_rclk !== com_rclk) pair_err++;
    if (seg_srclk && !p_srclk) begin
      seg_sh = {seg_sh[6:0], seg_ser};
      com_sh = {com_sh[6:0], com_ser};
    end
    if (seg_rclk && !p_rclk) rclk_rise = cyc;
    if (!seg_rclk && p_rclk) begin
      rclk_fall = cyc;
      lat_q.push_back({13'd0, scan_digit, seg_sh, com_sh});
    end
    if (!seg_oe && p_oe) oe_fall = cyc;
    if (seg_oe && !p_oe) begin
      oe_rise = cyc;
      oe_run  = cyc - oe_fall;
      n_oe_rise++;
    end
    if (frame_sync) begin
      n_sync++;
      last_sync = cyc;
    end
    p_srclk = seg_srclk;
    p_rclk  = seg_rclk;
    p_oe    = seg_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int d, input logic [7:0] s, input logic [7:0] c);
    return {13'd0, 3'(d), s, c};
  endfunction

  function automatic logic [31:0] entry(input int i);
    if (i < lat_q.size()) return lat_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [8:0] outs();
    return {seg_ser, seg_srclk, seg_rclk, seg_oe, com_ser, com_srclk, com_rclk, com_oe, frame_sync};
  endfunction

  function automatic logic [6:0] idle_outs();
    return {seg_srclk, seg_rclk, seg_oe, com_srclk, com_rclk, com_oe, frame_sync};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_latches(input string tag, input int target, input int budget);
    int k = 0;
    while (lat_q.size() < target && k < budget) begin tick(1); k++; end
    if (lat_q.size() < target) chk(tag, lat_q.size(), target);
  endtask

  task automatic wait_sync(input string tag, input int budget);
    int s0 = n_sync, k = 0;
    while (n_sync == s0 && k < budget) begin tick(1); k++; end
    if (n_sync == s0) chk(tag, n_sync, s0 + 1);
  endtask

  task automatic wait_digit(input string tag, input int d, input int budget);
    int k = 0;
    while (scan_digit != 3'(d) && k < budget) begin tick(1); k++; end
    if (scan_digit != 3'(d)) chk(tag, scan_digit, d);
  endtask

  task automatic wait_oe_rise(input string tag, input int r0, input int budget);
    int k = 0;
    while (n_oe_rise == r0 && k < budget) begin tick(1); k++; end
    if (n_oe_rise == r0) chk(tag, n_oe_rise, r0 + 1);
  endtask

  initial begin
    int s0, q0, q1, q2, r0, ns;
    tick(3);
    chk("rst_outs", outs(), 9'h022);
    chk("rst_digit", scan_digit, 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_no_enable", outs(), 9'h022);

    // First digit: glyph 0x06 on digit 0, common 0xFE
    frame_data = 32'h4F5B_3F06;
    frame_we = 1'b1; tick(1); frame_we = 1'b0;
    lat_q.delete();
    enable = 1'b1;
    wait_sync("sync0_timeout", 20);
    s0 = last_sync;
    wait_latches("lat0_timeout", 1, 200);
    chk("digit0_word", entry(0), ent(0, 8'h06, 8'hFE));
    chk("rclk_width", rclk_fall - rclk_rise, 4);
    chk("rclk_fall_ofs", rclk_fall - s0, 69);
    chk("oe_on_ofs", oe_fall - s0, 69);

    wait_digit("dig1_timeout", 1, 200);
    tick(10);
    chk("oe_in_shift", seg_oe, OE_SHIFT);

    // Free-running scan across all four digits and back to 0
    wait_latches("free_timeout", 5, 600);
    chk("digit1_word", entry(1), ent(1, 8'h3F, 8'hFD));
    chk("digit2_word", entry(2), ent(2, 8'h5B, 8'hFB));
    chk("digit3_word", entry(3), ent(3, 8'h4F, 8'hF7));
    chk("digit0_again", entry(4), ent(0, 8'h06, 8'hFE));
    chk("sync_period", last_sync - s0, 404);

    // Frame write during digit 2: takes effect only from the next digit 0
    wait_digit("dig2_timeout", 2, 500);
    q0 = lat_q.size();
    frame_data = 32'h7F07_6D66;
    frame_we = 1'b1; tick(1); frame_we = 1'b0;
    wait_latches("upd_timeout", q0 + 4, 600);
    chk("upd_d2_old", entry(q0),     ent(2, 8'h5B, 8'hFB));
    chk("upd_d3_old", entry(q0 + 1), ent(3, 8'h4F, 8'hF7));
    chk("upd_d0_new", entry(q0 + 2), ent(0, 8'h66, 8'hFE));
    chk("upd_d1_new", entry(q0 + 3), ent(1, 8'h6D, 8'hFD));

    // Disable mid-shift of digit 1: the digit completes, then IDLE
    wait_digit("dig2b_timeout", 2, 300);
    wait_digit("dig1b_timeout", 1, 400);
    tick(20);
    enable = 1'b0;
    q1 = lat_q.size();
    r0 = n_oe_rise;
    wait_latches("off_lat_timeout", q1 + 1, 200);
    chk("off_digit1_word", entry(q1), ent(1, 8'h6D, 8'hFD));
    wait_oe_rise("off_oe_timeout", r0, 200);
    chk("off_hold_len", oe_rise - rclk_fall, 32);
    tick(5);
    chk("off_idle_outs", idle_outs(), 7'b0010010);
    chk("off_idle_digit", scan_digit, 0);
    ns = n_sync;
    tick(150);
    chk("off_no_sync", n_sync, ns);

    // Asynchronous reset in the middle of HOLD
    enable = 1'b1;
    wait_sync("sync_r_timeout", 20);
    tick(80);
    chk("pre_rst_oe", seg_oe, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", outs(), 9'h022);
    tick(3);
    rst_n = 1'b1;
    q2 = lat_q.size();
    wait_latches("rst_lat_timeout", q2 + 1, 200);
    chk("rst_frame_clear", entry(q2), ent(0, 8'h00, 8'hFE));

`ifdef SEG7_BRIGHTNESS_EN
    brightness = 4'd3;
    q2 = lat_q.size();
    wait_latches("b3_timeout", q2 + 2, 400);
    r0 = n_oe_rise;
    wait_oe_rise("b3_oe_timeout", r0, 200);
    chk("bright3_on", oe_run, 8);
    brightness = 4'd15;
    q2 = lat_q.size();
    wait_latches("b15_timeout", q2 + 2, 400);
    r0 = n_oe_rise;
    wait_oe_rise("b15_oe_timeout", r0, 200);
    chk("bright15_on", oe_run, 32);
`endif

    chk("chains_equal", pair_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
